// File: rtl/sr_cmd_debounce.sv
// Command front end for the enabled SR latch: synchronises and debounces the raw
// set/reset/enable inputs and arbitrates them into clean S/R/Enable levels.
// Optional build macro SR_PULSE_MODE_EN: S/R become one-cycle pulses on state entry.
module sr_cmd_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SetBtn,
  input  logic             ResetBtn,
  input  logic             EnableSw,
  output logic             S,
  output logic             R,
  output logic             Enable,
  output logic             Conflict,
  output logic [EVT_W-1:0] EventCnt,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET      = 2'd1,
    ST_RST      = 2'd2,
    ST_CONFLICT = 2'd3
  } state_t;

  // Channel order everywhere: 0 = set, 1 = reset, 2 = enable.
  logic [2:0]             w_raw;
  logic [2:0]             w_sync;
  logic [SYNC_STAGES-1:0] r_sync [3];
  logic [CNT_W-1:0]       r_cnt  [3];
  logic [2:0]             r_db;

  assign w_raw = {EnableSw, ResetBtn, SetBtn};

  always_comb begin
    w_sync = '0;
    for (int i = 0; i < 3; i++) begin
      w_sync[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreement with the held value restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_db <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
        if (w_sync[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]  <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_s;
  logic             r_r;
  logic             r_conflict;
  logic             r_en;
  logic [EVT_W-1:0] r_evt;
  logic             w_enter_cmd;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_SET, ST_RST: begin
        unique case ({r_db[0], r_db[1]})
          2'b10:   w_next = ST_SET;
          2'b01:   w_next = ST_RST;
          2'b11:   w_next = ST_CONFLICT;
          default: w_next = ST_IDLE;
        endcase
      end
      ST_CONFLICT: begin
        // Only a full release leaves the conflict; a half release issues nothing.
        if (r_db[1:0] == 2'b00) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_cmd = ((w_next == ST_SET) && (r_state != ST_SET)) ||
                       ((w_next == ST_RST) && (r_state != ST_RST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_en       <= 1'b0;
      r_evt      <= '0;
    end else begin
      r_state    <= w_next;
`ifdef SR_PULSE_MODE_EN
      r_s        <= (w_next == ST_SET) && (r_state != ST_SET);
      r_r        <= (w_next == ST_RST) && (r_state != ST_RST);
`else
      r_s        <= (w_next == ST_SET);
      r_r        <= (w_next == ST_RST);
`endif
      r_conflict <= (w_next == ST_CONFLICT);
      r_en       <= r_db[2];
      if (w_enter_cmd) r_evt <= r_evt + EVT_W'(1);
    end
  end

  assign S           = r_s;
  assign R           = r_r;
  assign Enable      = r_en;
  assign Conflict    = r_conflict;
  assign EventCnt    = r_evt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed latencies, widths and counts.
`timescale 1ns/1ps
module tb_sr_cmd_debounce;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int EVT_W = 8;
  localparam int H     = SYNC + DEB;
`ifdef SR_PULSE_MODE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_SET  = 1;
  localparam int M_RST  = 2;
  localparam int M_CONF = 3;

  logic             clk;
  logic             rst_n;
  logic             set_btn;
  logic             reset_btn;
  logic             enable_sw;
  logic             s_out;
  logic             r_out;
  logic             en_out;
  logic             conf_out;
  logic [EVT_W-1:0] evt_out;
  logic [1:0]       dbg_state;
  logic [2:0]       raw;

  int n_checks;
  int n_errors;
  int s_hi_cnt;
  int r_hi_cnt;

  sr_cmd_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .EVT_W           (EVT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SetBtn      (set_btn),
    .ResetBtn    (reset_btn),
    .EnableSw    (enable_sw),
    .S           (s_out),
    .R           (r_out),
    .Enable      (en_out),
    .Conflict    (conf_out),
    .EventCnt    (evt_out),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign raw = {enable_sw, reset_btn, set_btn};

  // Reference model: a value is accepted once the last DEB synchronised samples
  // all disagree with the held value; the command follows pure priority rules.
  logic [H-1:0]     m_hist [3];
  logic [2:0]       m_db;
  int               m_state;
  logic             m_s;
  logic             m_r;
  logic             m_en;
  logic             m_conf;
  logic [EVT_W-1:0] m_evt;

  function automatic bit window_flips(input logic [H-1:0] h, input logic db);
    bit all_diff;
    all_diff = 1'b1;
    for (int k = SYNC - 1; k <= H - 2; k++) if (h[k] == db) all_diff = 1'b0;
    return all_diff;
  endfunction

  function automatic int cmd_next(input int cur, input logic s, input logic r);
    if (s && r)            return M_CONF;
    if (cur == M_CONF)     return (!s && !r) ? M_IDLE : M_CONF;
    if (s)                 return M_SET;
    if (r)                 return M_RST;
    return M_IDLE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_hist[i] <= '0;
      m_db    <= '0;
      m_state <= M_IDLE;
      m_s     <= 1'b0;
      m_r     <= 1'b0;
      m_en    <= 1'b0;
      m_conf  <= 1'b0;
      m_evt   <= '0;
    end else begin
      int nxt;
      bit entered_set;
      bit entered_rst;
      nxt = cmd_next(m_state, m_db[0], m_db[1]);
      entered_set = (nxt == M_SET) && (m_state != M_SET);
      entered_rst = (nxt == M_RST) && (m_state != M_RST);
      m_s    <= PULSE ? entered_set : (nxt == M_SET);
      m_r    <= PULSE ? entered_rst : (nxt == M_RST);
      m_conf <= (nxt == M_CONF);
      m_en   <= m_db[2];
      if (entered_set || entered_rst) m_evt <= m_evt + 1'b1;
      m_state <= nxt;
      for (int i = 0; i < 3; i++) begin
        if (window_flips(m_hist[i], m_db[i])) m_db[i] <= ~m_db[i];
        m_hist[i] <= {m_hist[i][H-2:0], raw[i]};
      end
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("S",        32'(s_out),    32'(m_s));
    check("R",        32'(r_out),    32'(m_r));
    check("Enable",   32'(en_out),   32'(m_en));
    check("Conflict", 32'(conf_out), 32'(m_conf));
    check("EventCnt", 32'(evt_out),  32'(m_evt));
    check("S_and_R",  32'(s_out & r_out), 32'd0);
    if (s_out === 1'b1) s_hi_cnt++;
    if (r_out === 1'b1) r_hi_cnt++;
  endtask

  // driver: every cycle is compared on the falling edge; inputs move 1ns after rise
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    enable_sw = 1'b0;
    rst_n     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  int s_before;
  int r_before;
  bit s_during_bounce;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    s_hi_cnt  = 0;
    r_hi_cnt  = 0;
    rst_n     = 1'b0;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    enable_sw = 1'b0;
    #1;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // 1: async reset mid-run, then full re-debounce of a held input
    set_btn = 1'b1;
    tick(25);
    check("t1_s_before_reset", 32'(s_out), PULSE ? 32'd0 : 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_async_s",    32'(s_out),    32'd0);
    check("t1_async_r",    32'(r_out),    32'd0);
    check("t1_async_en",   32'(en_out),   32'd0);
    check("t1_async_conf", 32'(conf_out), 32'd0);
    check("t1_async_evt",  32'(evt_out),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(18);
    check("t1_s_edge18", 32'(s_out), 32'd0);
    tick(1);
    check("t1_s_edge19", 32'(s_out), 32'd1);
    check("t1_evt",      32'(evt_out), 32'd1);

    // 2: bounce every 5 cycles, final level 1
    do_reset();
    s_during_bounce = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      set_btn = (i % 2 == 0);
      if (i < 20) begin
        for (int c = 0; c < 5; c++) begin
          tick(1);
          if (s_out) s_during_bounce = 1'b1;
        end
      end
    end
    check("t2_s_during_bounce", 32'(s_during_bounce), 32'd0);
    tick(18);
    check("t2_s_edge18", 32'(s_out), 32'd0);
    tick(1);
    check("t2_s_edge19", 32'(s_out), 32'd1);
    check("t2_evt",      32'(evt_out), 32'd1);

    // 3: clean set, idle gap, clean reset
    do_reset();
    set_btn = 1'b1;
    tick(50);
    check("t3_s_held", 32'(s_out), PULSE ? 32'd0 : 32'd1);
    check("t3_r_held", 32'(r_out), 32'd0);
    set_btn = 1'b0;
    tick(30);
    check("t3_gap_s", 32'(s_out), 32'd0);
    check("t3_gap_r", 32'(r_out), 32'd0);
    reset_btn = 1'b1;
    tick(30);
    check("t3_r_held", 32'(r_out), PULSE ? 32'd0 : 32'd1);
    check("t3_s_off",  32'(s_out), 32'd0);
    check("t3_evt",    32'(evt_out), 32'd2);
    reset_btn = 1'b0;
    tick(25);

    // 4: conflict entry, half release, full release
    do_reset();
    set_btn = 1'b1;
    tick(30);
    reset_btn = 1'b1;
    tick(18);
    check("t4_conf_edge18", 32'(conf_out), 32'd0);
    tick(1);
    check("t4_conf_edge19", 32'(conf_out), 32'd1);
    check("t4_s_dropped",   32'(s_out),    32'd0);
    reset_btn = 1'b0;
    tick(40);
    check("t4_conf_half", 32'(conf_out), 32'd1);
    check("t4_s_half",    32'(s_out),    32'd0);
    set_btn = 1'b0;
    tick(40);
    check("t4_conf_clear", 32'(conf_out), 32'd0);
    check("t4_r_clear",    32'(r_out),    32'd0);
    check("t4_evt",        32'(evt_out),  32'd1);

    // 5: event counter wrap and enable latency
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      set_btn = 1'b1;
      tick(20);
      set_btn = 1'b0;
      tick(20);
      if (p == 255) check("t5_evt_255", 32'(evt_out), 32'd255);
    end
    check("t5_evt_wrap", 32'(evt_out), 32'd0);
    enable_sw = 1'b1;
    tick(18);
    check("t5_en_edge18", 32'(en_out), 32'd0);
    tick(1);
    check("t5_en_edge19", 32'(en_out), 32'd1);
    enable_sw = 1'b0;
    tick(19);
    check("t5_en_off", 32'(en_out), 32'd0);

    // 6: command width for a 40-cycle press (pulse build gives one cycle)
    do_reset();
    s_before = s_hi_cnt;
    set_btn = 1'b1;
    tick(40);
    set_btn = 1'b0;
    tick(40);
    check("t6_s_width", 32'(s_hi_cnt - s_before), PULSE ? 32'd1 : 32'd40);
    check("t6_evt_set", 32'(evt_out), 32'd1);
    r_before = r_hi_cnt;
    reset_btn = 1'b1;
    tick(40);
    reset_btn = 1'b0;
    tick(40);
    check("t6_r_width", 32'(r_hi_cnt - r_before), PULSE ? 32'd1 : 32'd40);
    check("t6_evt_rst", 32'(evt_out), 32'd2);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
